// File: rtl/decoder3to8_hold.sv
// decoder3to8_hold: registered 3-to-8 one-hot decoder with a valid/ready
// input handshake. Each accepted index drives its line for HOLD_CYCLES
// cycles, followed by one all-zero gap cycle, so consecutive lines never
// overlap (break-before-make). Dropping en during the drive cuts the hold
// short; the gap cycle then reports aborted instead of done.
module decoder3to8_hold #(
  parameter int HOLD_CYCLES = 4,  // cycles each line stays high, 1..255
  parameter int CNT_W       = 8   // hold counter width, 2**CNT_W > HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] I,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // The counter holds the number of drive cycles still to come after the
  // current one, so a value of zero means this is the last drive cycle.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [7:0]       onehot;
  logic             accept;

  // One comparator per output line; exactly one of them matches any index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_decode
    assign onehot[gi] = (I == 3'(gi));
  end

  // rst_n is folded in so nothing upstream sees ready while held in reset.
  assign in_ready = en & (state_q == IDLE) & rst_n;
  assign accept   = in_valid & in_ready;

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        y_d    = 8'h00;
        busy_d = 1'b0;
        if (accept) begin
          state_d = DRIVE;
          y_d     = onehot;
          cnt_d   = HOLD_LOAD;
          busy_d  = 1'b1;
        end
      end

      DRIVE: begin
        busy_d = 1'b1;
        if (!en) begin
          // Abort takes precedence over normal completion.
          state_d   = GAP;
          y_d       = 8'h00;
          cnt_d     = '0;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          y_d     = 8'h00;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      GAP: begin
        // Single gap cycle, left unconditionally regardless of en.
        state_d = IDLE;
        y_d     = 8'h00;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        y_d     = 8'h00;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      y_q       <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign Y       = y_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_decoder3to8_hold.sv
// Directed testbench for decoder3to8_hold with HOLD_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_decoder3to8_hold;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] I;
  logic [7:0] Y;
  logic       busy;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;

  // Continuous monitors for the break-before-make guarantees.
  int         multihot_cnt = 0;
  int         direct_change_cnt = 0;
  int         both_pulse_cnt = 0;
  logic [7:0] y_prev = 8'h00;

  decoder3to8_hold #(
    .HOLD_CYCLES(4),
    .CNT_W      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .I       (I),
    .Y       (Y),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is fixed-length, this only guards hangs.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (!$onehot0(Y)) multihot_cnt++;
    if (y_prev != 8'h00 && Y != 8'h00 && Y != y_prev) direct_change_cnt++;
    if (done && aborted) both_pulse_cnt++;
    y_prev = Y;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Accept idx on the next edge and check the full drive/gap/idle sequence.
  task automatic run_hold(input logic [2:0] idx, input string tag);
    logic [7:0] exp_y;
    exp_y    = 8'h01 << idx;
    en       = 1'b1;
    in_valid = 1'b1;
    I        = idx;
    #1;
    check({tag, " ready c0"}, in_ready, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("%s Y c%0d", tag, c), Y, exp_y);
      check($sformatf("%s busy c%0d", tag, c), busy, 1);
      check($sformatf("%s done c%0d", tag, c), done, 0);
    end
    @(negedge clk);
    check({tag, " Y gap"}, Y, 8'h00);
    check({tag, " done gap"}, done, 1);
    check({tag, " aborted gap"}, aborted, 0);
    check({tag, " busy gap"}, busy, 1);
    @(negedge clk);
    #1;
    check({tag, " ready idle"}, in_ready, 1);
    check({tag, " busy idle"}, busy, 0);
    check({tag, " done idle"}, done, 0);
  endtask

  initial begin
    int         done_pulses;
    logic [7:0] exp_y;

    // Reset / idle with en low: nothing may be accepted.
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b1;
    I        = 3'd3;
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst Y", Y, 8'h00);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("en0 Y c%0d", c), Y, 8'h00);
      check($sformatf("en0 ready c%0d", c), in_ready, 0);
      check($sformatf("en0 busy c%0d", c), busy, 0);
    end

    // Single decode of index 5.
    run_hold(3'd5, "single5");

    // Sweep 0..7 with in_valid held high throughout.
    done_pulses = 0;
    en          = 1'b1;
    in_valid    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_y = 8'h01 << k;
      I     = 3'(k);
      #1;
      check($sformatf("sweep%0d ready", k), in_ready, 1);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        check($sformatf("sweep%0d Y c%0d", k, c), Y, exp_y);
        if (done) done_pulses++;
      end
      @(negedge clk);
      check($sformatf("sweep%0d Y gap", k), Y, 8'h00);
      if (done) done_pulses++;
      @(negedge clk);
      if (done) done_pulses++;
    end
    in_valid = 1'b0;
    check("sweep done pulses", done_pulses, 8);

    // Abort: en drops during the 2nd drive cycle.
    @(negedge clk);
    en       = 1'b1;
    in_valid = 1'b1;
    I        = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort Y c1", Y, 8'h80);
    @(negedge clk);
    check("abort Y c2", Y, 8'h80);
    en = 1'b0;
    @(negedge clk);
    check("abort Y gap", Y, 8'h00);
    check("abort aborted gap", aborted, 1);
    check("abort done gap", done, 0);
    check("abort busy gap", busy, 1);
    @(negedge clk);
    check("abort busy idle", busy, 0);
    check("abort aborted idle", aborted, 0);
    check("abort ready en0", in_ready, 0);
    @(negedge clk);
    check("abort ready en0 late", in_ready, 0);
    check("abort Y idle", Y, 8'h00);

    // Asynchronous reset in the middle of a drive.
    en       = 1'b1;
    in_valid = 1'b1;
    I        = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("areset Y before", Y, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset Y cleared", Y, 8'h00);
    check("areset busy cleared", busy, 0);
    check("areset ready low", in_ready, 0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("areset no done c%0d", c), done, 0);
      check($sformatf("areset no abort c%0d", c), aborted, 0);
    end
    run_hold(3'd0, "post_reset0");

    // Changing I during drive must not disturb the held line.
    en       = 1'b1;
    in_valid = 1'b1;
    I        = 3'd1;
    @(negedge clk);
    I = 3'd6;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("ichg Y c%0d", c), Y, 8'h02);
      #1;
      check($sformatf("ichg ready c%0d", c), in_ready, 0);
      @(negedge clk);
    end
    check("ichg Y gap", Y, 8'h00);
    check("ichg done gap", done, 1);
    @(negedge clk);
    #1;
    check("ichg ready idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ichg Y new", Y, 8'h40);
    for (int c = 0; c < 6; c++) @(negedge clk);

    check("mon multihot", multihot_cnt, 0);
    check("mon direct change", direct_change_cnt, 0);
    check("mon done+aborted", both_pulse_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder3to8_hold.md
# decoder3to8_hold

Registered 3-to-8 one-hot decoder with valid/ready input handshake and pulse stretching: the inverse of the 8-to-3 priority encoder. It accepts a 3-bit line index, drives the corresponding one-hot line `Y` for a parameterised number of cycles, then inserts one all-zero gap cycle so that successive lines never overlap (break-before-make). It sits downstream of the priority encoder: it turns an arbitrated request index back into a timed per-line strobe or grant.

## Interface
- `HOLD_CYCLES`, 4: cycles each decoded line stays high; legal range 1..255.
- `CNT_W`, 8: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: block enable; low blocks new accepts and aborts an active drive.
- `in_valid` input 1: `I` holds a valid index.
- `in_ready` output 1: block can accept; combinational, `en & (state==IDLE) & rst_n`.
- `I` input 3: line index to decode, 0..7.
- `Y` output 8: registered one-hot output (`1<<I`) or all zero.
- `busy` output 1: registered; high in DRIVE and GAP.
- `done` output 1: registered one-cycle pulse marking a hold that completed normally.
- `aborted` output 1: registered one-cycle pulse marking a hold cut short by `en` going low.

## Operation
- FSM states: IDLE, DRIVE, GAP.
- IDLE: `Y=0`, `busy=0`. Accept occurs when `in_valid & in_ready`. On accept, `I` is captured, `Y` is loaded with `1<<I`, the counter is loaded with `HOLD_CYCLES-1`, and the FSM moves to DRIVE.
- DRIVE: `Y` stays constant and `busy=1`.
  - If `en` is low, the FSM goes to GAP with `Y=0` and `aborted=1` for that one GAP cycle.
  - Otherwise, if the counter is 0, the FSM goes to GAP with `Y=0` and `done=1` for that one GAP cycle.
  - Otherwise the counter decrements.
- GAP: lasts exactly one cycle with `Y=0` and `busy=1`. The FSM then returns to IDLE unconditionally, whether or not `en` is high.
- `Y` is never multi-hot and never changes directly from one nonzero value to another. At least one zero cycle always separates two lines.
- `in_valid` with `en` low is ignored. No accept happens, and nothing is queued.
- `I` and `in_valid` are don't-care outside accept cycles. Changing `I` during DRIVE has no effect.
- `done` and `aborted` are mutually exclusive and are asserted only in the GAP cycle.
- Only one transaction is in flight at a time; there is no buffering.
- Reset mid-operation: all outputs clear asynchronously and the FSM returns to IDLE. No `done` or `aborted` is produced for the lost transaction.

## Timing
- Reset values: `Y=8'h00`, `busy=0`, `done=0`, `aborted=0`, state IDLE, counter 0. `in_ready=0` while `rst_n` is low.
- Latency from an accept at edge T: `Y` is valid from T+1 to T+HOLD_CYCLES inclusive.
- GAP occupies cycle T+HOLD_CYCLES+1, with `done=1` in that cycle.
- `in_ready` returns at T+HOLD_CYCLES+2, so the maximum accept rate is one per HOLD_CYCLES+2 cycles.
- Abort: if `en` is sampled low at the edge ending DRIVE cycle k, then `Y=0` and `aborted=1` in the next cycle, followed by IDLE.
- `HOLD_CYCLES=1`: `Y` is high for exactly one cycle, then GAP.

## Test plan
All scenarios use `HOLD_CYCLES=4`.
- Reset/idle: assert `rst_n=0`, then release with `en=0` and `in_valid=1`, `I=3` → `Y=00`, `in_ready=0`, `busy=0`, and no accept.
- Single decode: with `en=1`, accept `I=5` at cycle 0 → `Y=8'h20` for cycles 1–4, `Y=0` with `done=1` at cycle 5, and `in_ready=1` at cycle 6.
- Sweep with back-to-back valid: hold `in_valid=1` continuously with `I` cycling 0..7 → `Y` runs 01,02,04,…,80, each line 4 cycles followed by a 1-cycle zero gap. There must be exactly 8 `done` pulses and `Y` must never be multi-hot.
- Abort: accept `I=7`, then drop `en` in the 2nd DRIVE cycle → `Y=8'h80` for 2 cycles, then `Y=0` with `aborted=1` and `done=0`, then IDLE. With `en` still 0, `in_ready` stays low.
- Async reset mid-DRIVE: accept `I=2`, then pulse `rst_n` low between clock edges → `Y` clears immediately, with no `done` or `aborted`. A fresh accept after reset must work.
- Input change during DRIVE: accept `I=1`, then change `I` to 6 with `in_valid=1` during DRIVE → `Y` stays `8'h02` for the full hold. `I=6` is accepted only when `in_ready` returns.
